// File: rtl/version_reporter.sv
// version_reporter: snapshots the packed version/commit words on request.
// It decodes them into version fields and streams them as a framed byte
// sequence over a valid/ready byte interface that feeds the debug UART TX path.
//
// Frame: HEADER_BYTE, version_upper32 (MSB first), version_lower32 (MSB first).
// Optional build macro VERSION_REPORTER_CHECKSUM_EN appends one XOR checksum
// byte over the eight payload bytes. The header is not part of the checksum.
module version_reporter #(
  parameter logic [7:0] HEADER_BYTE        = 8'hA5,
  parameter logic       TX_HOLD_EN_DEFAULT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] version_upper32,
  input  logic [31:0] version_lower32,
  input  logic        req,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic [3:0]  ver_major,
  output logic [5:0]  ver_minor,
  output logic [5:0]  ver_patch,
  output logic [7:0]  ver_build,
  output logic [39:0] commit_id
);

`ifdef VERSION_REPORTER_CHECKSUM_EN
  localparam int unsigned FrameLen = 10;
`else
  localparam int unsigned FrameLen = 9;
`endif

  localparam logic [3:0] LastIdx = 4'(FrameLen - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] up_snap_q, lo_snap_q;
  logic        hold_q;
  logic        snap_load, snap_clear;
  logic        accept;
  logic [7:0]  frame_byte;

  assign accept = tx_valid && tx_ready;

  // State and byte counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a request is only honoured in IDLE; DONE always
  // returns to IDLE, so a request coinciding with done is dropped.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    snap_load  = 1'b0;
    snap_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d   = StSend;
          cnt_d     = 4'd0;
          snap_load = 1'b1;
        end
      end
      StSend: begin
        if (accept) begin
          if (cnt_q == LastIdx) begin
            state_d = StDone;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StDone: begin
        state_d    = StIdle;
        snap_clear = !hold_q;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Hold flag: when clear, the snapshot (and hence the decode) is dropped
  // once the frame completes; when set it persists until the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= TX_HOLD_EN_DEFAULT;
    end else begin
      hold_q <= hold_q;
    end
  end

  // Snapshot registers: the frame is built only from these, never from the
  // live inputs, so input changes mid-frame cannot leak into the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_snap_q <= 32'd0;
      lo_snap_q <= 32'd0;
    end else if (snap_load) begin
      up_snap_q <= version_upper32;
      lo_snap_q <= version_lower32;
    end else if (snap_clear) begin
      up_snap_q <= 32'd0;
      lo_snap_q <= 32'd0;
    end
  end

  // Registered field decode, one cycle behind the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ver_major <= 4'd0;
      ver_minor <= 6'd0;
      ver_patch <= 6'd0;
      ver_build <= 8'd0;
      commit_id <= 40'd0;
    end else begin
      ver_major <= up_snap_q[31:28];
      ver_minor <= up_snap_q[27:22];
      ver_patch <= up_snap_q[21:16];
      ver_build <= up_snap_q[15:8];
      commit_id <= {up_snap_q[7:0], lo_snap_q};
    end
  end

`ifdef VERSION_REPORTER_CHECKSUM_EN
  logic [7:0] checksum;

  // XOR over the eight payload bytes of the snapshot.
  always_comb begin
    checksum = up_snap_q[31:24] ^ up_snap_q[23:16] ^ up_snap_q[15:8] ^ up_snap_q[7:0] ^
               lo_snap_q[31:24] ^ lo_snap_q[23:16] ^ lo_snap_q[15:8] ^ lo_snap_q[7:0];
  end
`endif

  // Byte selector: counter index into the frame.
  always_comb begin
    frame_byte = 8'h00;
    case (cnt_q)
      4'd0:    frame_byte = HEADER_BYTE;
      4'd1:    frame_byte = up_snap_q[31:24];
      4'd2:    frame_byte = up_snap_q[23:16];
      4'd3:    frame_byte = up_snap_q[15:8];
      4'd4:    frame_byte = up_snap_q[7:0];
      4'd5:    frame_byte = lo_snap_q[31:24];
      4'd6:    frame_byte = lo_snap_q[23:16];
      4'd7:    frame_byte = lo_snap_q[15:8];
      4'd8:    frame_byte = lo_snap_q[7:0];
`ifdef VERSION_REPORTER_CHECKSUM_EN
      4'd9:    frame_byte = checksum;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  // Moore outputs; tx_data is zeroed outside SEND so idle/reset reads 0.
  // The counter only moves on accept, so tx_data is stable under backpressure.
  always_comb begin
    tx_valid = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    tx_data  = 8'h00;
    unique case (state_q)
      StSend: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = frame_byte;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_version_reporter.sv
// Scoreboard bench for version_reporter. The driver pushes expected frames and
// decodes at request time. A negedge monitor pops and compares them.
module tb_version_reporter;

  localparam logic [7:0] Hdr = 8'hA5;
`ifdef VERSION_REPORTER_CHECKSUM_EN
  localparam int FrameLen = 10;
`else
  localparam int FrameLen = 9;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] up, lo;
  logic        req;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy, done;
  logic [3:0]  ver_major;
  logic [5:0]  ver_minor, ver_patch;
  logic [7:0]  ver_build;
  logic [39:0] commit_id;

  always #5 clk = ~clk;

  version_reporter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .version_upper32 (up),
    .version_lower32 (lo),
    .req             (req),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .done            (done),
    .ver_major       (ver_major),
    .ver_minor       (ver_minor),
    .ver_patch       (ver_patch),
    .ver_build       (ver_build),
    .commit_id       (commit_id)
  );

  typedef struct packed {
    logic [3:0]  major;
    logic [5:0]  minor;
    logic [5:0]  patch;
    logic [7:0]  build;
    logic [39:0] commit;
  } dec_t;

  logic [7:0] sb[$];
  dec_t       dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int byte_cnt = 0;
  int req_cyc = 0;
  int exp_done = 0;
  int ready_mode = 0;
  bit lat_arm = 0;
  bit chk_idle = 0;
  bit chk_done = 0;
  bit chk_empty = 0;
  bit timeout_flag = 0;

  // Reference model: a frame is the header, the 64-bit word split into bytes
  // MSB first, and optionally the XOR of those eight bytes.
  function automatic void push_frame(input logic [31:0] u, input logic [31:0] l);
    logic [63:0] w;
    logic [7:0]  b;
    logic [7:0]  ck;
    w  = {u, l};
    ck = 8'h00;
    sb.push_back(Hdr);
    for (int i = 0; i < 8; i++) begin
      b  = 8'((w >> (56 - 8 * i)) & 64'hFF);
      ck = ck ^ b;
      sb.push_back(b);
    end
`ifdef VERSION_REPORTER_CHECKSUM_EN
    sb.push_back(ck);
`endif
  endfunction

  function automatic dec_t model_dec(input logic [31:0] u, input logic [31:0] l);
    dec_t d;
    d.major  = 4'((u >> 28) & 32'hF);
    d.minor  = 6'((u >> 22) & 32'h3F);
    d.patch  = 6'((u >> 16) & 32'h3F);
    d.build  = 8'((u >> 8) & 32'hFF);
    d.commit = ({8'h00, u} << 32 | {8'h00, l}) & 40'hFF_FFFF_FFFF;
    return d;
  endfunction

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready generator: 0 = always ready, 1 = fixed 1-0-0-1 pattern, 2 = random.
  initial begin
    int pi;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    pi = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: begin
          tx_ready = pat[pi];
          pi = (pi + 1) % 4;
        end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: all comparisons happen here.
  logic [7:0] mon_exp;
  dec_t       mon_dec, mon_act;
  logic       prev_pend = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial forever begin
    @(negedge clk);
    if (chk_idle) begin
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00 ||
          ver_major !== 4'd0 || ver_minor !== 6'd0 || ver_patch !== 6'd0 ||
          ver_build !== 8'd0 || commit_id !== 40'd0) begin
        errors++;
        $display("FAIL reset_state: valid=%b busy=%b done=%b data=%h dec=%h/%h/%h/%h/%h, required all 0",
                 tx_valid, busy, done, tx_data, ver_major, ver_minor, ver_patch, ver_build,
                 commit_id);
      end
    end
    if (timeout_flag) begin
      checks++;
      errors++;
      $display("FAIL timeout: DUT event not seen within bound, required it to occur");
    end
    if (chk_done) begin
      checks++;
      if (done_cnt != exp_done) begin
        errors++;
        $display("FAIL done_count: got %0d, required %0d", done_cnt, exp_done);
      end
    end
    if (chk_empty) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: %0d bytes outstanding, required 0", sb.size());
      end
    end
    if (rst_n !== 1'b1) begin
      prev_pend = 1'b0;
      byte_cnt  = 0;
    end else begin
      if (prev_pend) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h",
                   tx_valid, tx_data, prev_data);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got %h, required no byte", tx_data);
        end else begin
          mon_exp = sb.pop_front();
          if (tx_data !== mon_exp) begin
            errors++;
            $display("FAIL byte[%0d]: got %h, required %h", byte_cnt, tx_data, mon_exp);
          end
        end
        byte_cnt++;
      end
      prev_pend = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
      prev_data = tx_data;
      if (done === 1'b1) begin
        done_cnt++;
        byte_cnt = 0;
        mon_act = {ver_major, ver_minor, ver_patch, ver_build, commit_id};
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done pulse, required none");
        end else begin
          mon_dec = dq.pop_front();
          if (mon_act !== mon_dec) begin
            errors++;
            $display("FAIL decode: got %h/%h/%h/%h/%h, required %h/%h/%h/%h/%h",
                     mon_act.major, mon_act.minor, mon_act.patch, mon_act.build,
                     mon_act.commit, mon_dec.major, mon_dec.minor, mon_dec.patch,
                     mon_dec.build, mon_dec.commit);
          end
        end
        // Counting the request cycle and the done cycle inclusively gives
        // FrameLen + 2 cycles, i.e. done lands FrameLen + 1 cycles after req.
        if (lat_arm) begin
          checks++;
          if (cyc - req_cyc != FrameLen + 1) begin
            errors++;
            $display("FAIL done_latency: got %0d, required %0d", cyc - req_cyc, FrameLen + 1);
          end
        end
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_state: valid=%b busy=%b, required 0/0", tx_valid, busy);
        end
      end
    end
  end

  task automatic issue_req(input logic [31:0] u, input logic [31:0] l, input bit expect_frame);
    @(posedge clk);
    #1;
    up  = u;
    lo  = l;
    req = 1'b1;
    if (expect_frame) begin
      push_frame(u, l);
      dq.push_back(model_dec(u, l));
      req_cyc = cyc;
    end
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic raise_timeout();
    #1;
    timeout_flag = 1'b1;
    @(negedge clk);
    #1;
    timeout_flag = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 400);
    if (done !== 1'b1) raise_timeout();
    else #1;
  endtask

  task automatic wait_bytes(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (byte_cnt < target && n < 200);
    if (byte_cnt < target) raise_timeout();
  endtask

  task automatic check_idle();
    #1;
    chk_idle = 1'b1;
    @(negedge clk);
    #1;
    chk_idle = 1'b0;
  endtask

  task automatic check_done_count(input int expected);
    #1;
    exp_done = expected;
    chk_done = 1'b1;
    @(negedge clk);
    #1;
    chk_done = 1'b0;
  endtask

  task automatic check_empty();
    #1;
    chk_empty = 1'b1;
    @(negedge clk);
    #1;
    chk_empty = 1'b0;
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    up    = 32'd0;
    lo    = 32'd0;
    req   = 1'b0;
    repeat (2) @(negedge clk);
    check_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle();

    // Basic decode and stream with continuous ready; latency checked.
    ready_mode = 0;
    lat_arm = 1'b1;
    issue_req(32'h123456AB, 32'hCDEF0123, 1'b1);
    wait_done();
    lat_arm = 1'b0;

    // Backpressure with the 1-0-0-1 pattern.
    ready_mode = 1;
    issue_req(32'h123456AB, 32'hCDEF0123, 1'b1);
    wait_done();

    // Snapshot isolation: inputs change after byte 2 is accepted.
    ready_mode = 2;
    issue_req(32'h123456AB, 32'hCDEF0123, 1'b1);
    wait_bytes(3);
    up = 32'hFFFFFFFF;
    lo = 32'h00000000;
    wait_done();

    // Request while busy is ignored; request right after done is honoured.
    ready_mode = 0;
    d0 = done_cnt;
    issue_req(32'h0BADF00D, 32'h76543210, 1'b1);
    wait_bytes(4);
    @(posedge clk);
    #1;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_done();
    issue_req(32'h13579BDF, 32'h2468ACE0, 1'b1);
    wait_done();
    check_done_count(d0 + 2);
    check_empty();

    // Reset mid-frame: outputs and decode clear before any clock edge.
    issue_req(32'hDEADBEEF, 32'hFEEDFACE, 1'b1);
    wait_bytes(3);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    dq.delete();
    check_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_done_count(d0);
    issue_req(32'hA1B2C3D4, 32'hE5F60718, 1'b1);
    wait_done();

    // All-zero words.
    issue_req(32'h0, 32'h0, 1'b1);
    wait_done();

    // Randomized frames under mixed ready behaviour.
    for (int i = 0; i < 8; i++) begin
      ready_mode = int'($urandom_range(0, 2));
      issue_req($urandom, $urandom, 1'b1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check_empty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
